cpu_io_bridge: RTL and testbench
================================

// Module: cpu_io_bridge
// PURPOSE
//  Host-side counterpart of the CPU top's trigger/a0 pins. Turns a raw push-button
//  into a clean one-cycle trigger pulse for the CPU. Captures every change of the
//  CPU's a0 register into a small FIFO, drained over a valid/ready stream to the
//  display/host interface. Shares the CPU's clock domain.
// PARAMETERS
//  DATA_WIDTH       32  width of a0 and out_data
//  DEBOUNCE_CYCLES  4   stable cycles required to accept a press or a release (>=1)
//  FIFO_DEPTH       4   a0 capture FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1                          system clock, rising edge
//  rst        in   1                          asynchronous, active-low reset
//  btn_in     in   1                          raw asynchronous button level, 1=pressed
//  trigger    out  1                          one-cycle pulse to CPU trigger input
//  a0         in   DATA_WIDTH                 CPU a0 output, synchronous to clk
//  out_data   out  DATA_WIDTH                 FIFO head value
//  out_valid  out  1                          FIFO non-empty
//  out_ready  in   1                          consumer accepts head this cycle
//  count      out  $clog2(FIFO_DEPTH)+1       current FIFO occupancy
//  overflow   out  1                          sticky: a capture was dropped
// BEHAVIOUR
//  Reset (rst=0, async): trigger=0, out_valid=0, out_data=0, count=0,
//   overflow=0, FSM=IDLE, debounce counter=0, synchronizer=0, a0_prev=0.
//   Reset mid-press or mid-stream discards FIFO contents and any pending pulse.
//  Button path: btn_in -> 2-flop synchronizer -> btn_s.
//  Debounce FSM (states IDLE, CONFIRM, HELD, RELEASE; counter cnt):
//   IDLE:    btn_s=1 -> CONFIRM, cnt=0.
//   CONFIRM: btn_s=0 -> IDLE; cnt==DEBOUNCE_CYCLES-1 & btn_s=1 -> HELD; else cnt++.
//   HELD:    btn_s=0 -> RELEASE, cnt=0.
//   RELEASE: btn_s=1 -> HELD (no new pulse); cnt==DEBOUNCE_CYCLES-1 & btn_s=0 -> IDLE;
//            else cnt++.
//   trigger is registered, high exactly for the first cycle in HELD after CONFIRM.
//   Latency: first edge sampling btn_in=1 is edge 1; trigger high after edge
//   DEBOUNCE_CYCLES+3, low one edge later. One pulse per accepted press,
//   regardless of hold length; glitches shorter than DEBOUNCE_CYCLES produce none.
//  a0 capture: a0_prev <= a0 every cycle. push = (a0 != a0_prev). No push for
//   a0 == 0 immediately after reset.
//  FIFO: pop = out_valid & out_ready. Registered, no fall-through: value pushed
//   at edge N is visible on out_data with out_valid=1 after edge N.
//   out_data/out_valid hold stable while out_valid & !out_ready.
//   Full & push & !pop: new value dropped, overflow<=1 (sticky until reset),
//    count stays FIFO_DEPTH.
//   Full & push & pop: both occur, count unchanged, no overflow.
//   Empty & pop impossible (out_valid=0). Empty & push: count 0->1.
//   Pointers wrap modulo FIFO_DEPTH; count = wr-rd on extra-bit pointers.
//   out_data when empty: last head value (don't-care to consumer).
// TESTING
//  1 DEBOUNCE_CYCLES=4: btn_in 0->1, held 20 cycles -> single trigger pulse after
//    edge 7, no further pulses; release, re-press after 10 cycles -> second pulse.
//  2 btn_in high 2 cycles then low -> trigger never asserts, FSM back to IDLE.
//  3 out_ready=1, a0 steps 0->5->5->9 on consecutive edges -> stream delivers 5
//    then 9, each one edge after its change; count never exceeds 1.
//  4 out_ready=0, a0 changes 6 times (1..6), FIFO_DEPTH=4 -> count=4, overflow=1,
//    then out_ready=1 drains exactly 1,2,3,4 in order, count returns to 0.
//  5 FIFO full, out_ready=1, a0 changes same cycle -> count stays 4, overflow
//    stays 0, new value appears as last element.
//  6 rst asserted low while HELD with 3 FIFO entries -> trigger=0, out_valid=0,
//    count=0, overflow=0 immediately without a clock edge.

Source files
------------

// File: rtl/cpu_io_bridge.sv
// Host-side bridge for the CPU: debounced one-cycle trigger from a push-button,
// and a small FIFO that captures every change of the CPU's a0 register.
module cpu_io_bridge #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          btn_in,
    output logic                          trigger,
    input  logic [DATA_WIDTH-1:0]         a0,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONFIRM = 2'd1;
    localparam logic [1:0] S_HELD    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    // Two-flop synchronizer for the asynchronous button level
    logic btn_meta;
    logic btn_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= btn_in;
            btn_s    <= btn_meta;
        end
    end

    // Debounce FSM: state register
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             trigger_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            trigger <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            trigger <= trigger_nxt;
        end
    end

    // Debounce FSM: next state; the pulse fires only on CONFIRM -> HELD
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        trigger_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (btn_s) begin
                    state_nxt = S_CONFIRM;
                    cnt_nxt   = '0;
                end
            end
            S_CONFIRM: begin
                if (!btn_s) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = S_HELD;
                    trigger_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_HELD: begin
                if (!btn_s) begin
                    state_nxt = S_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            S_RELEASE: begin
                if (btn_s) begin
                    state_nxt = S_HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // a0 change capture and FIFO storage
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] a0_prev;
    logic [PTR_W:0]        wr_ptr;
    logic [PTR_W:0]        rd_ptr;
    logic [PTR_W:0]        wr_ptr_nxt;
    logic [PTR_W:0]        rd_ptr_nxt;
    logic [PTR_W:0]        count_nxt;
    logic [DATA_WIDTH-1:0] out_data_nxt;
    logic                  overflow_nxt;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  wr_en;
    logic [PTR_W-1:0]      wr_idx;
    logic [PTR_W-1:0]      rd_idx_nxt;

    assign push       = (a0 != a0_prev);
    assign pop        = out_valid & out_ready;
    assign full       = (count == OCC_FULL);
    assign wr_en      = push & (~full | pop);
    assign wr_idx     = wr_ptr[PTR_W-1:0];
    assign rd_idx_nxt = rd_ptr[PTR_W-1:0] + PTR_W'(1);

    // Registered head: reloads from storage on pop, or takes a0 directly when the
    // incoming value becomes the new head (empty, or last entry popped this cycle)
    always_comb begin
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        out_data_nxt = out_data;
        overflow_nxt = overflow;
        if (wr_en) begin
            wr_ptr_nxt = wr_ptr + (PTR_W+1)'(1);
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + (PTR_W+1)'(1);
        end
        if (push & full & ~pop) begin
            overflow_nxt = 1'b1;
        end
        count_nxt = wr_ptr_nxt - rd_ptr_nxt;
        if (!out_valid) begin
            if (wr_en) begin
                out_data_nxt = a0;
            end
        end else if (pop) begin
            if (count > (PTR_W+1)'(1)) begin
                out_data_nxt = mem[rd_idx_nxt];
            end else if (wr_en) begin
                out_data_nxt = a0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            a0_prev   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_idx] <= a0;
            end
            a0_prev   <= a0;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            out_data  <= out_data_nxt;
            overflow  <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Bench for cpu_io_bridge: run-length button model plus queue-based FIFO model,
// compared every cycle, with directed scenarios pinned by literal expectations.
module tb_cpu_io_bridge;

    localparam int unsigned DW  = 32;
    localparam int unsigned DEB = 4;
    localparam int unsigned DEP = 4;

    logic          clk;
    logic          rst;
    logic          btn_in;
    logic          trigger;
    logic [DW-1:0] a0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    count;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    cpu_io_bridge #(
        .DATA_WIDTH(DW),
        .DEBOUNCE_CYCLES(DEB),
        .FIFO_DEPTH(DEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .trigger(trigger),
        .a0(a0),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count(count),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a press/release is accepted after DEB+1 consecutive
    // synchronized samples opposing the accepted level; FIFO is a plain queue.
    bit            m_s1, m_s2, m_bs, m_acc, m_trig, m_ovf, m_push, m_pop;
    int            m_run, m_n;
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_prev, m_last;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_s1 = 0; m_s2 = 0; m_run = 0; m_acc = 0; m_trig = 0; m_ovf = 0;
            m_q.delete(); m_prev = '0; m_last = '0;
        end else begin
            m_bs = m_s2; m_s2 = m_s1; m_s1 = btn_in;
            m_trig = 0;
            if (m_bs != m_acc) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_acc = m_bs; m_run = 0; m_trig = m_bs;
                end
            end else begin
                m_run = 0;
            end
            m_n = m_q.size();
            m_push = (a0 != m_prev);
            m_prev = a0;
            m_pop = (m_n != 0) && out_ready;
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_n == DEP && !m_pop) m_ovf = 1;
                else m_q.push_back(a0);
            end
            if (m_q.size() != 0) m_last = m_q[0];
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("m_trigger", trigger, m_trig);
            chk("m_out_valid", out_valid, m_q.size() != 0);
            chk("m_out_data", out_data, (m_q.size() != 0) ? m_q[0] : m_last);
            chk("m_count", count, m_q.size());
            chk("m_overflow", overflow, m_ovf);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_btn(input int n, output int pulses, output int first);
        pulses = 0;
        first  = -1;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (trigger) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
    endtask

    int pulses, first;

    initial begin
        rst = 1'b0; btn_in = 1'b0; a0 = '0; out_ready = 1'b0;
        #1;
        chk("rst_trigger", trigger, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        repeat (2) tick();
        rst = 1'b1;

        // single pulse per press, two presses
        btn_in = 1'b1;
        run_btn(20, pulses, first);
        chk("t1_pulses", pulses, 1);
        chk("t1_edge", first, 7);
        btn_in = 1'b0;
        run_btn(10, pulses, first);
        chk("t1_release_pulses", pulses, 0);
        btn_in = 1'b1;
        run_btn(20, pulses, first);
        chk("t1_repress_pulses", pulses, 1);
        chk("t1_repress_edge", first, 7);
        btn_in = 1'b0;
        repeat (10) tick();

        // short glitch rejected, FSM returns to idle
        btn_in = 1'b1;
        tick(); tick();
        btn_in = 1'b0;
        run_btn(15, pulses, first);
        chk("t2_glitch_pulses", pulses, 0);
        btn_in = 1'b1;
        run_btn(10, pulses, first);
        chk("t2_after_edge", first, 7);
        btn_in = 1'b0;
        repeat (10) tick();

        // streaming with ready high
        out_ready = 1'b1;
        a0 = 5; tick();
        chk("t3_v1", out_valid, 1); chk("t3_d1", out_data, 5); chk("t3_c1", count, 1);
        a0 = 5; tick();
        chk("t3_v2", out_valid, 0); chk("t3_c2", count, 0);
        a0 = 9; tick();
        chk("t3_v3", out_valid, 1); chk("t3_d3", out_data, 9); chk("t3_c3", count, 1);
        tick();
        chk("t3_v4", out_valid, 0); chk("t3_d4_hold", out_data, 9);

        // overflow and ordered drain
        out_ready = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            a0 = DW'(v);
            tick();
        end
        chk("t4_count", count, 4);
        chk("t4_overflow", overflow, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain_valid", out_valid, 1);
            chk("t4_drain_data", out_data, 64'(i + 1));
            tick();
        end
        chk("t4_empty_count", count, 0);
        chk("t4_empty_valid", out_valid, 0);
        chk("t4_sticky", overflow, 1);

        // full with simultaneous push and pop
        a0 = '0; btn_in = 1'b0; out_ready = 1'b0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        for (int v = 11; v <= 14; v++) begin
            a0 = DW'(v);
            tick();
        end
        chk("t5_full", count, 4);
        out_ready = 1'b1;
        a0 = 15;
        tick();
        chk("t5_count", count, 4);
        chk("t5_overflow", overflow, 0);
        chk("t5_head", out_data, 12);
        for (int i = 0; i < 4; i++) begin
            chk("t5_drain_data", out_data, 64'(12 + i));
            tick();
        end
        chk("t5_empty", count, 0);

        // async reset while held with entries pending
        out_ready = 1'b0;
        btn_in = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            if (i >= 5) a0 = DW'(16 + i);
            tick();
        end
        chk("t6_pre_trigger", trigger, 1);
        chk("t6_pre_count", count, 3);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_trigger", trigger, 0);
        chk("t6_valid", out_valid, 0);
        chk("t6_count", count, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_data", out_data, 0);
        btn_in = 1'b0;
        a0 = '0;
        tick();
        rst = 1'b1;
        run_btn(10, pulses, first);
        chk("t6_no_pulse", pulses, 0);
        chk("t6_post_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
